// File: rtl/dcache_wb_buffer_pkg.sv
// Shared types for the data-cache write-back buffer.
// Bus commands, address layout and buffer entry format.
package dcache_wb_buffer_pkg;

  localparam int WB_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic [55:0] tag;
    logic [4:0]  set_index;
    logic [2:0]  ignore;
  } SASS_ADDR;

  typedef struct packed {
    logic        valid;
    SASS_ADDR    addr;
    logic [63:0] data;
  } WB_ENTRY_t;

  typedef enum logic {
    WB_IDLE,
    WB_REQ
  } wb_state_e;

  function automatic logic [63:0] bus_addr(input SASS_ADDR a);
    return {a.tag, a.set_index, 3'b000};
  endfunction

endpackage

// File: rtl/dcache_wb_match.sv
// Associative search of the write-back FIFO.
// Scans oldest to youngest so the youngest match wins.
module dcache_wb_match
  import dcache_wb_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF,
  parameter int PW    = $clog2(DEPTH)
) (
  input  SASS_ADDR                addr_i,
  input  WB_ENTRY_t [DEPTH-1:0]   ent_i,
  input  logic      [PW:0]        head_i,
  input  logic      [PW:0]        tail_i,
  output logic                    hit_o,
  output logic      [PW-1:0]      idx_o
);

  logic [PW:0]   cnt;
  logic [PW-1:0] idx;
  logic          unused_bits;

  assign cnt         = tail_i - head_i;
  assign unused_bits = ^{ent_i, addr_i.ignore};

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i[PW-1:0] + PW'(k);
      if (((PW+1)'(k) < cnt) && ent_i[idx].valid &&
          (ent_i[idx].addr.tag == addr_i.tag) &&
          (ent_i[idx].addr.set_index == addr_i.set_index)) begin
        hit_o = 1'b1;
        idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer: queues dirty victims, drains them as
// BUS_STORE requests, and lets load misses snoop pending lines.
module dcache_wb_buffer
  import dcache_wb_buffer_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        evict_en,
  input  logic        evict_valid,
  input  logic        evict_dirty,
  input  SASS_ADDR    evict_addr,
  input  logic [63:0] evict_data,
  output logic        wb_full,
  output logic        wb_empty,
  input  logic        lookup_en,
  input  SASS_ADDR    lookup_addr,
  output logic        lookup_hit,
  output logic [63:0] lookup_data,
  input  logic        mem_grant,
  output BUS_COMMAND  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response
);

  localparam int PW = $clog2(WB_DEPTH);

  WB_ENTRY_t [WB_DEPTH-1:0] ent_q, ent_d;
  logic [PW:0]   head_q, head_d;
  logic [PW:0]   tail_q, tail_d;
  wb_state_e     state_q, state_d;

  logic          evict_ok, issue, pop;
  logic          co_hit, coalesce, alloc;
  logic [PW-1:0] co_idx;
  logic          lk_hit;
  logic [PW-1:0] lk_idx;
  WB_ENTRY_t     head_ent;

  assign wb_full  = (head_q[PW-1:0] == tail_q[PW-1:0]) &&
                    (head_q[PW] != tail_q[PW]);
  assign wb_empty = (head_q == tail_q);
  assign head_ent = ent_q[head_q[PW-1:0]];

  assign evict_ok = evict_en & evict_valid & evict_dirty & ~wb_full;
  assign issue    = (state_q == WB_REQ) & mem_grant;
  assign pop      = issue & (|mem2proc_response);

  // A line leaving on the bus this cycle cannot absorb new data.
  assign coalesce = evict_ok & co_hit &
                    ~(pop & (co_idx == head_q[PW-1:0]));
  assign alloc    = evict_ok & ~coalesce;

  dcache_wb_match #(.DEPTH(WB_DEPTH), .PW(PW)) u_co_match (
    .addr_i (evict_addr),
    .ent_i  (ent_q),
    .head_i (head_q),
    .tail_i (tail_q),
    .hit_o  (co_hit),
    .idx_o  (co_idx)
  );

  dcache_wb_match #(.DEPTH(WB_DEPTH), .PW(PW)) u_lk_match (
    .addr_i (lookup_addr),
    .ent_i  (ent_q),
    .head_i (head_q),
    .tail_i (tail_q),
    .hit_o  (lk_hit),
    .idx_o  (lk_idx)
  );

  assign lookup_hit  = lookup_en & lk_hit;
  assign lookup_data = lookup_hit ? ent_q[lk_idx].data : '0;

  assign proc2mem_command = issue ? BUS_STORE : BUS_NONE;
  assign proc2mem_addr    = issue ? bus_addr(head_ent.addr) : '0;
  assign proc2mem_data    = issue ? head_ent.data : '0;

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      ent_d[head_q[PW-1:0]].valid = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (coalesce) begin
      ent_d[co_idx].data = evict_data;
    end
    if (alloc) begin
      ent_d[tail_q[PW-1:0]] = '{valid: 1'b1,
                                addr:  evict_addr,
                                data:  evict_data};
      tail_d = tail_q + 1'b1;
    end
    state_d = (head_d != tail_d) ? WB_REQ : WB_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      state_q <= WB_IDLE;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer: a cycle table plus
// hand-written full/drop and mid-drain reset sequences.
module tb_dcache_wb_buffer;
  import dcache_wb_buffer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        evict_en, evict_valid, evict_dirty;
  SASS_ADDR    evict_addr;
  logic [63:0] evict_data;
  logic        wb_full, wb_empty;
  logic        lookup_en;
  SASS_ADDR    lookup_addr;
  logic        lookup_hit;
  logic [63:0] lookup_data;
  logic        mem_grant;
  BUS_COMMAND  proc2mem_command;
  logic [63:0] proc2mem_addr, proc2mem_data;
  logic [3:0]  mem2proc_response;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  ev;
    logic [63:0] ea, ed;
    logic        le;
    logic [63:0] la;
    logic        g;
    logic [3:0]  r;
    logic        full, empty, hit;
    logic [63:0] ldata;
    BUS_COMMAND  cmd;
    logic [63:0] paddr, pdata;
  } vec_t;

  vec_t vecs[$];

  dcache_wb_buffer dut (
    .clock             (clock),
    .reset             (reset),
    .evict_en          (evict_en),
    .evict_valid       (evict_valid),
    .evict_dirty       (evict_dirty),
    .evict_addr        (evict_addr),
    .evict_data        (evict_data),
    .wb_full           (wb_full),
    .wb_empty          (wb_empty),
    .lookup_en         (lookup_en),
    .lookup_addr       (lookup_addr),
    .lookup_hit        (lookup_hit),
    .lookup_data       (lookup_data),
    .mem_grant         (mem_grant),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ev, input logic [63:0] ea,
                       input logic [63:0] ed, input logic le,
                       input logic [63:0] la, input logic g,
                       input logic [3:0] r);
    {evict_en, evict_valid, evict_dirty} = ev;
    evict_addr        = SASS_ADDR'(ea);
    evict_data        = ed;
    lookup_en         = le;
    lookup_addr       = SASS_ADDR'(la);
    mem_grant         = g;
    mem2proc_response = r;
  endtask

  task automatic bus(input string nm, input BUS_COMMAND c,
                     input logic [63:0] a, input logic [63:0] d);
    chk({nm, ".cmd"},  64'(proc2mem_command), 64'(c));
    chk({nm, ".addr"}, proc2mem_addr, a);
    chk({nm, ".data"}, proc2mem_data, d);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(
    input logic [2:0] ev, input logic [63:0] ea, input logic [63:0] ed,
    input logic le, input logic [63:0] la, input logic g,
    input logic [3:0] r, input logic full, input logic empty,
    input logic hit, input logic [63:0] ldata, input BUS_COMMAND cmd,
    input logic [63:0] paddr, input logic [63:0] pdata);
    vec_t v;
    v.ev = ev; v.ea = ea; v.ed = ed; v.le = le; v.la = la;
    v.g = g; v.r = r; v.full = full; v.empty = empty; v.hit = hit;
    v.ldata = ldata; v.cmd = cmd; v.paddr = paddr; v.pdata = pdata;
    return v;
  endfunction

  initial begin
    string nm;
    drive(3'b000, 0, 0, 1'b1, 0, 1'b1, 4'd1);

    // single store path
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BUS_NONE, 0, 0));
    vecs.push_back(mk(3'b111, 'h1008, 'hDEAD, 0, 0, 1, 1,
                      0, 1, 0, 0, BUS_NONE, 0, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 1, 1,
                      0, 0, 0, 0, BUS_STORE, 'h1008, 'hDEAD));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, BUS_NONE, 0, 0));
    // coalescing and lookup
    vecs.push_back(mk(3'b111, 'h2000, 'hA, 0, 0, 0, 0,
                      0, 1, 0, 0, BUS_NONE, 0, 0));
    vecs.push_back(mk(3'b111, 'h2000, 'hB, 1, 'h2000, 0, 0,
                      0, 0, 1, 'hA, BUS_NONE, 0, 0));
    vecs.push_back(mk(3'b000, 0, 0, 1, 'h2000, 0, 0,
                      0, 0, 1, 'hB, BUS_NONE, 0, 0));
    vecs.push_back(mk(3'b000, 0, 0, 1, 'h3000, 0, 0,
                      0, 0, 0, 0, BUS_NONE, 0, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 'h2000, 0, 0,
                      0, 0, 0, 0, BUS_NONE, 0, 0));
    // retry until a non-zero response
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(3'b000, 0, 0, 0, 0, 1, 0,
                        0, 0, 0, 0, BUS_STORE, 'h2000, 'hB));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 1, 2,
                      0, 0, 0, 0, BUS_STORE, 'h2000, 'hB));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, BUS_NONE, 0, 0));
    // evict matching the head while it is popped allocates anew
    vecs.push_back(mk(3'b111, 'h4000, 1, 0, 0, 0, 0,
                      0, 1, 0, 0, BUS_NONE, 0, 0));
    vecs.push_back(mk(3'b111, 'h4000, 2, 0, 0, 1, 1,
                      0, 0, 0, 0, BUS_STORE, 'h4000, 1));
    vecs.push_back(mk(3'b000, 0, 0, 1, 'h4000, 1, 1,
                      0, 0, 1, 2, BUS_STORE, 'h4000, 2));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, BUS_NONE, 0, 0));
    // clean and invalid victims are dropped
    vecs.push_back(mk(3'b110, 'h5000, 5, 0, 0, 1, 1,
                      0, 1, 0, 0, BUS_NONE, 0, 0));
    vecs.push_back(mk(3'b101, 'h5000, 5, 0, 0, 1, 1,
                      0, 1, 0, 0, BUS_NONE, 0, 0));
    vecs.push_back(mk(3'b000, 0, 0, 1, 'h5000, 1, 1,
                      0, 1, 0, 0, BUS_NONE, 0, 0));

    // reset state
    tick();
    chk("rst.full", wb_full, 0);
    chk("rst.empty", wb_empty, 1);
    chk("rst.hit", lookup_hit, 0);
    chk("rst.ldata", lookup_data, 0);
    bus("rst", BUS_NONE, 0, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      nm = $sformatf("v%0d", i);
      drive(vecs[i].ev, vecs[i].ea, vecs[i].ed, vecs[i].le,
            vecs[i].la, vecs[i].g, vecs[i].r);
      #2;
      chk({nm, ".full"},  wb_full,     vecs[i].full);
      chk({nm, ".empty"}, wb_empty,    vecs[i].empty);
      chk({nm, ".hit"},   lookup_hit,  vecs[i].hit);
      chk({nm, ".ldata"}, lookup_data, vecs[i].ldata);
      bus(nm, vecs[i].cmd, vecs[i].paddr, vecs[i].pdata);
      tick();
    end

    // fill to full, drop a fifth evict, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 64'h6000 + 64'(8 * i), 64'h60 + 64'(i), 0, 0, 0, 0);
      #2;
      chk($sformatf("fill%0d.full", i), wb_full, 0);
      tick();
    end
    drive(3'b111, 'h7000, 'h70, 0, 0, 0, 0);
    #2;
    chk("full.full", wb_full, 1);
    chk("full.empty", wb_empty, 0);
    bus("full", BUS_NONE, 0, 0);
    tick();
    drive(3'b000, 0, 0, 1, 'h7000, 0, 0);
    #2;
    chk("drop.full", wb_full, 1);
    chk("drop.hit", lookup_hit, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive((i == 0) ? 3'b111 : 3'b000, 'h7100, 'h71, 0, 0, 1, 1);
      #2;
      nm = $sformatf("drain%0d", i);
      chk({nm, ".full"}, wb_full, (i == 0));
      bus(nm, BUS_STORE, 64'h6000 + 64'(8 * i), 64'h60 + 64'(i));
      tick();
    end
    drive(3'b000, 0, 0, 0, 0, 1, 1);
    #2;
    chk("drained.empty", wb_empty, 1);
    bus("drained", BUS_NONE, 0, 0);
    tick();

    // reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      drive(3'b111, 64'h8000 + 64'(8 * i), 64'h80 + 64'(i), 0, 0, 0, 0);
      tick();
    end
    drive(3'b000, 0, 0, 0, 0, 1, 1);
    #2;
    bus("mid0", BUS_STORE, 'h8000, 'h80);
    tick();
    drive(3'b000, 0, 0, 1, 'h8010, 1, 1);
    #1;
    bus("mid1", BUS_STORE, 'h8008, 'h81);
    reset = 1'b0;
    #1;
    chk("arst.empty", wb_empty, 1);
    chk("arst.full", wb_full, 0);
    chk("arst.hit", lookup_hit, 0);
    bus("arst", BUS_NONE, 0, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      nm = $sformatf("post%0d", i);
      chk({nm, ".empty"}, wb_empty, 1);
      bus(nm, BUS_NONE, 0, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
